// File: rtl/memory_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_arbiter_pkg                                                   |
// | Request/response bus types shared by the core and memory side.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package memory_arbiter_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_fence;
    logic        mem_spec;
    logic [1:0]  mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic        mem_ready;
  } mem_out_type;

endpackage
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_arbiter                                                       |
// | Round-robin arbiter sharing one memory bus between imem and dmem.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module memory_arbiter
  import memory_arbiter_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out
);

  localparam logic [1:0] C_IDLE   = 2'd0;
  localparam logic [1:0] C_BUSY_I = 2'd1;
  localparam logic [1:0] C_BUSY_D = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  mem_in_type r_ipend;
  mem_in_type r_dpend;
  logic       r_last;

  logic       w_done;
  logic       w_issue_pt;
  logic       w_i_live;
  logic       w_d_live;
  logic       w_i_cand;
  logic       w_d_cand;
  logic       w_grant_i;
  logic       w_grant_d;
  mem_in_type w_i_req;
  mem_in_type w_d_req;

  assign w_done     = mem_out.mem_ready && (r_state != C_IDLE);
  assign w_issue_pt = (r_state == C_IDLE) || w_done;

  // A port's live request is ignored while it owns the bus, except on the
  // completing cycle where it may be re-issued without a bubble.
  assign w_i_live = imem_in.mem_valid && ((r_state != C_BUSY_I) || mem_out.mem_ready);
  assign w_d_live = dmem_in.mem_valid && ((r_state != C_BUSY_D) || mem_out.mem_ready);

  assign w_i_req  = w_i_live ? imem_in : r_ipend;
  assign w_d_req  = w_d_live ? dmem_in : r_dpend;
  assign w_i_cand = w_i_live || r_ipend.mem_valid;
  assign w_d_cand = w_d_live || r_dpend.mem_valid;

  // r_last high means data was granted last, so instruction wins a tie.
  assign w_grant_i = w_issue_pt && w_i_cand && (!w_d_cand || r_last);
  assign w_grant_d = w_issue_pt && w_d_cand && (!w_i_cand || !r_last);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ipend <= '0;
      r_dpend <= '0;
      r_last  <= 1'b1;
    end else begin
      if (w_grant_i) begin
        r_ipend <= '0;
      end else if (w_i_live) begin
        r_ipend <= imem_in;
      end
      if (w_grant_d) begin
        r_dpend <= '0;
      end else if (w_d_live) begin
        r_dpend <= dmem_in;
      end
      if (w_grant_i || w_grant_d) begin
        r_last <= w_grant_d;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_grant_i) begin
      w_state_next = C_BUSY_I;
    end else if (w_grant_d) begin
      w_state_next = C_BUSY_D;
    end else if (w_done) begin
      w_state_next = C_IDLE;
    end
  end

  always_comb begin
    mem_in   = '0;
    imem_out = '0;
    dmem_out = '0;
    if (w_grant_i) begin
      mem_in           = w_i_req;
      mem_in.mem_valid = 1'b1;
    end else if (w_grant_d) begin
      mem_in           = w_d_req;
      mem_in.mem_valid = 1'b1;
    end
    // A ready seen in idle belongs to an abandoned transaction and is dropped.
    if (mem_out.mem_ready) begin
      case (r_state)
        C_BUSY_I: imem_out = mem_out;
        C_BUSY_D: dmem_out = mem_out;
        default:  ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_memory_arbiter                                                    |
// | Scoreboard bench: directed stimulus, queued expectations, monitor.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  mem_in_type  imem_in;
  mem_out_type imem_out;
  mem_in_type  dmem_in;
  mem_out_type dmem_out;
  mem_in_type  mem_in;
  mem_out_type mem_out;

  mem_in_type  exp_req[$];
  mem_out_type exp_i[$];
  mem_out_type exp_d[$];
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;

  always #5 clock = ~clock;

  memory_arbiter dut (
    .clock    (clock),
    .reset    (reset),
    .imem_in  (imem_in),
    .imem_out (imem_out),
    .dmem_in  (dmem_in),
    .dmem_out (dmem_out),
    .mem_in   (mem_in),
    .mem_out  (mem_out)
  );

  function automatic mem_in_type req(input bit instr, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [3:0] wstrb);
    mem_in_type r;
    r           = '0;
    r.mem_valid = 1'b1;
    r.mem_instr = instr;
    r.mem_mode  = 2'b11;
    r.mem_addr  = addr;
    r.mem_wdata = wdata;
    r.mem_wstrb = wstrb;
    return r;
  endfunction

  function automatic mem_out_type rsp(input logic [31:0] rdata, input logic err);
    mem_out_type r;
    r.mem_rdata = rdata;
    r.mem_error = err;
    r.mem_ready = 1'b1;
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  // Monitor: every request/response the DUT presents is matched against the queues.
  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      if (mem_in.mem_valid) begin
        if (exp_req.size() == 0) begin
          errors++;
          $display("FAIL req_unexpected: got %h required none", mem_in);
        end else if (mem_in !== exp_req[0]) begin
          errors++;
          $display("FAIL req: got %h required %h", mem_in, exp_req[0]);
          void'(exp_req.pop_front());
        end else begin
          void'(exp_req.pop_front());
        end
      end else if (mem_in !== '0) begin
        errors++;
        $display("FAIL req_idle: got %h required 0", mem_in);
      end

      checks++;
      if (imem_out.mem_ready) begin
        if (exp_i.size() == 0) begin
          errors++;
          $display("FAIL iresp_unexpected: got %h required none", imem_out);
        end else begin
          if (imem_out !== exp_i[0]) begin
            errors++;
            $display("FAIL iresp: got %h required %h", imem_out, exp_i[0]);
          end
          void'(exp_i.pop_front());
        end
      end else if (imem_out !== '0) begin
        errors++;
        $display("FAIL iresp_idle: got %h required 0", imem_out);
      end

      checks++;
      if (dmem_out.mem_ready) begin
        if (exp_d.size() == 0) begin
          errors++;
          $display("FAIL dresp_unexpected: got %h required none", dmem_out);
        end else begin
          if (dmem_out !== exp_d[0]) begin
            errors++;
            $display("FAIL dresp: got %h required %h", dmem_out, exp_d[0]);
          end
          void'(exp_d.pop_front());
        end
      end else if (dmem_out !== '0) begin
        errors++;
        $display("FAIL dresp_idle: got %h required 0", dmem_out);
      end
    end
  end

  initial begin
    imem_in = '0;
    dmem_in = '0;
    mem_out = '0;
    reset   = 1'b0;
    step();
    mon_en  = 1'b1;
    step();
    reset   = 1'b1;
    step();

    // Single fetch, ready two cycles after the request
    imem_in = req(1'b1, 32'h8000_0000, 32'h0, 4'h0);
    exp_req.push_back(imem_in);
    step();
    imem_in = '0;
    step();
    mem_out = rsp(32'h0000_0013, 1'b0);
    exp_i.push_back(mem_out);
    step();
    mem_out = '0;
    step();

    // Tie straight after reset: fetch first, load from pending slot
    do_reset();
    imem_in = req(1'b1, 32'h8000_0000, 32'h0, 4'h0);
    dmem_in = req(1'b0, 32'h8000_1000, 32'h0, 4'h0);
    exp_req.push_back(imem_in);
    step();
    exp_req.push_back(dmem_in);
    imem_in = '0;
    dmem_in = '0;
    mem_out = rsp(32'h1111_1111, 1'b0);
    exp_i.push_back(mem_out);
    step();
    mem_out = rsp(32'h2222_2222, 1'b0);
    exp_d.push_back(mem_out);
    step();
    mem_out = '0;
    step();

    // Round-robin with both ports requesting and 1-cycle memory latency
    imem_in = req(1'b1, 32'h8000_0010, 32'h0, 4'h0);
    dmem_in = req(1'b0, 32'h8000_1010, 32'h0, 4'h0);
    exp_req.push_back(imem_in);
    step();
    exp_req.push_back(dmem_in);
    imem_in = req(1'b1, 32'h8000_0014, 32'h0, 4'h0);
    mem_out = rsp(32'hA000_0001, 1'b0);
    exp_i.push_back(mem_out);
    step();
    exp_req.push_back(imem_in);
    dmem_in = req(1'b0, 32'h8000_1014, 32'h0, 4'h0);
    mem_out = rsp(32'hA000_0002, 1'b0);
    exp_d.push_back(mem_out);
    step();
    exp_req.push_back(dmem_in);
    imem_in = '0;
    mem_out = rsp(32'hA000_0003, 1'b0);
    exp_i.push_back(mem_out);
    step();
    dmem_in = '0;
    mem_out = rsp(32'hA000_0004, 1'b0);
    exp_d.push_back(mem_out);
    step();
    mem_out = '0;
    step();

    // Store arrives while a fetch is outstanding and is held unchanged
    imem_in = req(1'b1, 32'h8000_0100, 32'h0, 4'h0);
    exp_req.push_back(imem_in);
    step();
    imem_in = '0;
    dmem_in = req(1'b0, 32'h8000_2004, 32'hDEAD_BEEF, 4'hF);
    dmem_in.mem_fence = 1'b1;
    dmem_in.mem_spec  = 1'b1;
    step();
    exp_req.push_back(dmem_in);
    dmem_in = '0;
    mem_out = rsp(32'h0000_0033, 1'b0);
    exp_i.push_back(mem_out);
    step();
    mem_out = rsp(32'h0, 1'b0);
    exp_d.push_back(mem_out);
    step();
    mem_out = '0;
    step();

    // Load completing with an error goes to dmem only
    dmem_in = req(1'b0, 32'h8000_3000, 32'h0, 4'h0);
    exp_req.push_back(dmem_in);
    step();
    dmem_in = '0;
    mem_out = rsp(32'h0000_0BAD, 1'b1);
    exp_d.push_back(mem_out);
    step();
    mem_out = '0;
    step();

    // Reset during busy_d; late ready in idle is dropped
    dmem_in = req(1'b0, 32'h8000_4000, 32'h0, 4'h0);
    exp_req.push_back(dmem_in);
    step();
    dmem_in = '0;
    reset   = 1'b0;
    step();
    reset   = 1'b1;
    mem_out = rsp(32'h5555_5555, 1'b0);
    step();
    mem_out = '0;
    imem_in = req(1'b1, 32'h8000_0200, 32'h0, 4'h0);
    exp_req.push_back(imem_in);
    step();
    imem_in = '0;
    mem_out = rsp(32'h0000_0077, 1'b0);
    exp_i.push_back(mem_out);
    step();
    mem_out = '0;
    step();
    step();

    checks++;
    if (exp_req.size() != 0) begin
      errors++;
      $display("FAIL req_missing: got %0d left required 0", exp_req.size());
    end
    checks++;
    if (exp_i.size() != 0) begin
      errors++;
      $display("FAIL iresp_missing: got %0d left required 0", exp_i.size());
    end
    checks++;
    if (exp_d.size() != 0) begin
      errors++;
      $display("FAIL dresp_missing: got %0d left required 0", exp_d.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port to one-port memory arbiter that shares a single memory bus between the instruction fetch path (the fetch buffer's `imem` port) and the data path (load/store `dmem` port). It sits between the core and the unified memory or bus interface. It grants one transaction at a time with round-robin priority and holds a losing request in a per-port pending slot. It routes each response back to the port that owns the in-flight transaction. An idle arbiter adds zero cycles of latency.

## Interface
- No parameters; all widths come from `mem_in_type` / `mem_out_type`.
- `clock`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `imem_in`  in  mem_in_type  instruction request (`mem_instr`=1, re-asserted every cycle until served).
- `imem_out`  out  mem_out_type  instruction response.
- `dmem_in`  in  mem_in_type  data request (load/store/fence).
- `dmem_out`  out  mem_out_type  data response.
- `mem_in`  out  mem_in_type  shared memory request.
- `mem_out`  in  mem_out_type  shared memory response.

## Operation
- States: `idle` (no transaction outstanding), `busy_i` (instruction outstanding), `busy_d` (data outstanding). Registers: `state`, `ipend`/`dpend` (valid bit plus full mem_in_type copy), and `last` (1 = data granted last).
- Capture rule: when `X_in.mem_valid`=1 and port X is neither outstanding nor being issued this cycle, the request is written into `Xpend`. A later valid on the same port overwrites the slot. While port X is outstanding, `X_in.mem_valid` is ignored.
- Candidate per port: the live input if its `mem_valid`=1, otherwise the pending slot. The live input always wins over a stale pending copy.
- Issue point: `state`=`idle`, or the cycle in which `mem_out.mem_ready`=1 ends the current transaction.
- Selection at an issue point:
  - If only one port has a candidate, that port is selected.
  - If both have candidates, select instruction when `last`=1 and data when `last`=0.
- On issue:
  - `mem_in` = selected candidate with `mem_valid`=1 for exactly that cycle.
  - The selected port's pending slot is cleared.
  - `state` becomes `busy_i` or `busy_d`.
  - `last` is updated to the selected port.
- All `mem_in` fields pass through unchanged, including `mem_fence`, `mem_spec`, `mem_mode`, `mem_wdata`, `mem_wstrb` and `mem_instr`. When nothing is issued, `mem_in` is all-zero.
- Response routing when `mem_out.mem_ready`=1:
  - In `busy_i`: `imem_out` = `mem_out` and `dmem_out` = 0.
  - In `busy_d`: `dmem_out` = `mem_out` and `imem_out` = 0.
  - In `idle`: the response is dropped and both outputs stay 0.
- After completion, `state` goes to the state of any same-cycle issue, otherwise to `idle`.
- `mem_rdata` and `mem_error` are forwarded only together with `mem_ready`; otherwise both are 0.

## Timing
- Reset (`reset`=0 at a clock edge): `state`=`idle`, `ipend`=`dpend`=0, `last`=1 (instruction wins the first tie). Outputs are combinational, so `mem_in`, `imem_out` and `dmem_out` are all-zero whenever no request is presented.
- Request path: zero-cycle pass-through from `X_in` to `mem_in` in `idle`.
- Response path: zero-cycle pass-through from `mem_out` to `X_out`.
- Back-to-back: the next request issues in the same cycle as the previous `mem_ready`, so there is no bubble.
- Simultaneous `mem_ready` and new valid on the completing port: the new request is eligible for issue in that same cycle.
- Reset while busy: state is abandoned. A late `mem_ready` arriving in `idle` is dropped and not routed to either port.
- At most one outstanding transaction; `mem_in.mem_valid` is never asserted while busy except on the completing cycle.

## Test plan
- Single fetch: reset, then `imem_in` valid with addr 0x80000000; memory returns `mem_ready` after 2 cycles with rdata 0x00000013. Required: `mem_in.mem_valid`=1 and `mem_instr`=1 in the request cycle; `imem_out.mem_ready`=1 with rdata 0x00000013 in the response cycle; `dmem_out`=0 throughout.
- Tie after reset: both ports valid in the same cycle (fetch 0x80000000, load 0x80001000). Required: fetch issued first; load held in `dpend` and issued in fetch's `mem_ready` cycle; load data returned only on `dmem_out`.
- Round-robin: both ports request continuously for 4 transactions at 1-cycle memory latency. Required: grant order I, D, I, D with `mem_in.mem_valid` high every cycle.
- Store held: store with addr 0x80002004, wdata 0xDEADBEEF, wstrb 0xF arrives while a fetch is outstanding. Required: issued after fetch ready with addr, wdata and wstrb unchanged.
- Error routing: data load completes with `mem_error`=1. Required: `dmem_out.mem_error`=1 and `mem_ready`=1; `imem_out`=0.
- Reset mid-transaction: assert reset during `busy_d`, then deliver `mem_ready`=1 in `idle`. Required: both response ports stay 0, and the next fetch issues normally with zero latency.
